// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the MIPS memory-access stage.
// The state encodings are part of the stage's external contract, so they are fixed explicitly.
package mem_stage_pkg;
    localparam int XLEN  = 32;
    localparam int REG_W = 5;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_WAIT = 2'd1,
        MS_DONE = 2'd2
    } ms_state_e;

    // Memory data is only valid in the cycle the access completes; otherwise forward the ALU result.
    function automatic logic [XLEN-1:0] wb_select(input logic            memtoreg,
                                                  input logic            done,
                                                  input logic [XLEN-1:0] rdata,
                                                  input logic [XLEN-1:0] alu);
        return (memtoreg && done) ? rdata : alu;
    endfunction
endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the memory stage (master) and data memory (slave).
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic            dmem_ack;
    logic [XLEN-1:0] dmem_rdata;

    modport master (output dmem_req, dmem_we, dmem_addr, dmem_wdata,
                    input  dmem_ack, dmem_rdata);
    modport slave  (input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
                    output dmem_ack, dmem_rdata);
endinterface

// File: rtl/mem_access_ctrl.sv
// Data-memory access sequencer: IDLE/WAIT/DONE FSM with a timeout counter and registered bus outputs.
// The request fields are latched on entry to WAIT and held until the access ends.
module mem_access_ctrl
    import mem_stage_pkg::*;
#(
    parameter int DMEM_TIMEOUT = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              access_i,
    input  logic              we_i,
    input  logic [XLEN-1:0]   addr_i,
    input  logic [XLEN-1:0]   wdata_i,
    mem_stage_if.master       dmem,
    output logic              busy_o,
    output logic              done_o,
    output logic              fault_o,
    output logic [XLEN-1:0]   rdata_o
);
    ms_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q, req_d;
    logic             we_q, we_d;
    logic [XLEN-1:0]  addr_q, addr_d;
    logic [XLEN-1:0]  wdata_q, wdata_d;
    logic [XLEN-1:0]  rdata_q, rdata_d;
    logic             fault_q, fault_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= MS_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        fault_d = 1'b0;
        unique case (state_q)
            MS_IDLE: begin
                if (access_i) begin
                    state_d = MS_WAIT;
                    req_d   = 1'b1;
                    we_d    = we_i;
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    cnt_d   = CNT_W'(DMEM_TIMEOUT);
                end
            end
            MS_WAIT: begin
                if (dmem.dmem_ack) begin
                    rdata_d = dmem.dmem_rdata;
                    req_d   = 1'b0;
                    state_d = MS_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    // Abort with zero data when the last allowed WAIT cycle passes without ack.
                    if (cnt_q == CNT_W'(1)) begin
                        rdata_d = '0;
                        req_d   = 1'b0;
                        fault_d = 1'b1;
                        state_d = MS_DONE;
                    end
                end
            end
            MS_DONE: state_d = MS_IDLE;
            default: state_d = MS_IDLE;
        endcase
    end

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;

    assign busy_o  = ((state_q == MS_IDLE) && access_i) || (state_q == MS_WAIT);
    assign done_o  = (state_q == MS_DONE);
    assign fault_o = fault_q;
    assign rdata_o = rdata_q;
endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: drives the data-memory handshake, holds MEM/WB and produces EXECUTE's forwarding signals.
// DONE does not stall, so EX/MEM advances on the edge that writes the load result into MEM/WB.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DMEM_TIMEOUT = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              branch,
    input  logic              jump,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              MemtoReg,
    input  logic              RegWrite,
    input  logic [XLEN-1:0]   alu_out,
    input  logic [XLEN-1:0]   readdata2,
    input  logic [REG_W-1:0]  muxRegDst,
    mem_stage_if.master       dmem,
    output logic              mem_stall,
    output logic              mem_fault,
    output logic              pcsrc,
    output logic              jump_taken,
    output logic [REG_W-1:0]  MEMRegRd_wire,
    output logic              MEM_RegWrite_wire,
    output logic [XLEN-1:0]   regExMem,
    output logic [REG_W-1:0]  WBRegRd_wire,
    output logic              WB_RegWrite_wire,
    output logic [XLEN-1:0]   regMemWb
);
    logic             access;
    logic             busy;
    logic             done;
    logic [XLEN-1:0]  rdata_q;

    logic [REG_W-1:0] wb_rd_q, wb_rd_d;
    logic             wb_we_q, wb_we_d;
    logic [XLEN-1:0]  wb_val_q, wb_val_d;

    assign access = MemRead | MemWrite;

    mem_access_ctrl #(
        .DMEM_TIMEOUT(DMEM_TIMEOUT)
    ) u_ctrl (
        .CLK      (CLK),
        .RST      (RST),
        .access_i (access),
        .we_i     (MemWrite),
        .addr_i   (alu_out),
        .wdata_i  (readdata2),
        .dmem     (dmem),
        .busy_o   (busy),
        .done_o   (done),
        .fault_o  (mem_fault),
        .rdata_o  (rdata_q)
    );

    assign mem_stall         = busy;
    assign pcsrc             = branch & (alu_out != '0);
    assign jump_taken        = jump;
    assign MEMRegRd_wire     = muxRegDst;
    assign MEM_RegWrite_wire = RegWrite;
    assign regExMem          = alu_out;

    always_comb begin
        wb_rd_d  = '0;
        wb_we_d  = 1'b0;
        wb_val_d = '0;
        if (!mem_stall) begin
            wb_rd_d  = muxRegDst;
            wb_we_d  = RegWrite;
            wb_val_d = wb_select(MemtoReg, done, rdata_q, alu_out);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wb_rd_q  <= '0;
            wb_we_q  <= 1'b0;
            wb_val_q <= '0;
        end else begin
            wb_rd_q  <= wb_rd_d;
            wb_we_q  <= wb_we_d;
            wb_val_q <= wb_val_d;
        end
    end

    assign WBRegRd_wire     = wb_rd_q;
    assign WB_RegWrite_wire = wb_we_q;
    assign regMemWb         = wb_val_q;
endmodule
